// File: rtl/bist_pattern_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the BIST pattern controller:
//   - bist_state_e : controller FSM states (IDLE, RUN, DONE)
//   - MODE_EXH / MODE_LFSR : values of the mode input sampled with start
//   - bist_clog2   : ceiling log2 used to size the pattern counter
// Optional feature macro used by the block: BIST_PAUSE_EN.
// -----------------------------------------------------------------------------
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_e;

    localparam logic MODE_EXH  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int bist_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bist_pattern_ctrl_if.sv
// -----------------------------------------------------------------------------
// bist_pattern_ctrl_if
// Bundles the control, CUT and result signals of bist_pattern_ctrl.
//   start, mode      : run request and pattern mode from the test-control side
//   pat_out, resp_in : pattern to the CUT and its combinational response
//   busy, done, signature, pass : run status and result
//   pause            : run stall, present only when BIST_PAUSE_EN is defined
// Modports:
//   slave  - the controller itself
//   master - the test-control register / CUT side
// -----------------------------------------------------------------------------
interface bist_pattern_ctrl_if #(
    parameter int N_IN  = 5,
    parameter int N_OUT = 2,
    parameter int SIG_W = 16
) ();

    logic             start;
    logic             mode;
    logic [N_IN-1:0]  pat_out;
    logic [N_OUT-1:0] resp_in;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;
    logic             pass;
`ifdef BIST_PAUSE_EN
    logic             pause;
`endif

    modport slave (
        input  start,
        input  mode,
        input  resp_in,
`ifdef BIST_PAUSE_EN
        input  pause,
`endif
        output pat_out,
        output busy,
        output done,
        output signature,
        output pass
    );

    modport master (
        output start,
        output mode,
        output resp_in,
`ifdef BIST_PAUSE_EN
        output pause,
`endif
        input  pat_out,
        input  busy,
        input  done,
        input  signature,
        input  pass
    );

endinterface

// File: rtl/bist_pattern_ctrl_misr.sv
// -----------------------------------------------------------------------------
// bist_misr
// Multiple-input signature register: a Galois shift register with feedback
// mask MISR_POLY into which din is XORed every enabled cycle.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : fold din into the signature this cycle
//   din        : SIG_W-bit input word (already zero-extended by the caller)
//   sig        : current signature
// -----------------------------------------------------------------------------
module bist_misr #(
    parameter int               SIG_W     = 16,
    parameter logic [SIG_W-1:0] MISR_POLY = 16'h002D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? MISR_POLY : '0)
                  ^ din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// bist_pattern_ctrl
// On-chip pattern generator and response compactor for combinational CUTs.
// A start pulse (from IDLE or DONE) launches a run of PAT_CNT patterns, either
// an exhaustive binary count from 0 or a Galois LFSR sequence seeded with
// all-ones. Each RUN cycle the CUT response is folded into a MISR; on the last
// pattern the controller enters DONE and registers pass = (signature == GOLDEN).
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : bist_pattern_ctrl_if.slave (start, mode, resp_in, [pause],
//                pat_out, busy, done, signature, pass)
// Optional feature: define BIST_PAUSE_EN to add bus.pause, which stalls the
// pattern, counter and signature while high during RUN.
// -----------------------------------------------------------------------------
module bist_pattern_ctrl
    import bist_pkg::*;
#(
    parameter int               N_IN      = 5,
    parameter int               N_OUT     = 2,
    parameter int               SIG_W     = 16,
    parameter int               PAT_CNT   = 32,
    parameter logic [N_IN-1:0]  LFSR_POLY = 5'b00101,
    parameter logic [SIG_W-1:0] MISR_POLY = 16'h002D,
    parameter logic [SIG_W-1:0] GOLDEN    = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bist_pattern_ctrl_if.slave   bus
);

    localparam int CNT_W = bist_clog2(PAT_CNT) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAT_CNT - 1);

    bist_state_e      state_q, state_d;
    logic [N_IN-1:0]  pat_q,   pat_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q,  mode_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             pass_q,  pass_d;

    logic             run_adv;
    logic             misr_clr;
    logic [N_IN-1:0]  pat_step;
    logic [SIG_W-1:0] resp_ext;
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] sig_step;

    assign resp_ext = SIG_W'(bus.resp_in);

`ifdef BIST_PAUSE_EN
    assign run_adv = (state_q == RUN) && !bus.pause;
`else
    assign run_adv = (state_q == RUN);
`endif

    // Next pattern in the sequence selected at start.
    always_comb begin
        if (mode_q == MODE_LFSR) begin
            pat_step = {pat_q[N_IN-2:0], 1'b0} ^ (pat_q[N_IN-1] ? LFSR_POLY : '0);
        end else begin
            pat_step = pat_q + N_IN'(1);
        end
    end

    // The value the MISR loads on this edge; pass must compare against it
    // because pass is registered on the same edge that enters DONE.
    assign sig_step = {sig[SIG_W-2:0], 1'b0}
                    ^ (sig[SIG_W-1] ? MISR_POLY : '0)
                    ^ resp_ext;

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        count_d  = count_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        misr_clr = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    mode_d   = bus.mode;
                    count_d  = '0;
                    pat_d    = (bus.mode == MODE_LFSR) ? '1 : '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    misr_clr = 1'b1;
                end
            end
            RUN: begin
                if (run_adv) begin
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_CNT) begin
                        // Last pattern: pat_out keeps showing it in DONE.
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (sig_step == GOLDEN);
                    end else begin
                        pat_d = pat_step;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            count_q <= '0;
            mode_q  <= MODE_EXH;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    bist_misr #(
        .SIG_W     (SIG_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr),
        .en    (run_adv),
        .din   (resp_ext),
        .sig   (sig)
    );

    assign bus.pat_out   = pat_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.signature = sig;
    assign bus.pass      = pass_q;

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bist_pattern_ctrl
// Three controller instances:
//   u_c17 : c17 CUT, N_IN=5, PAT_CNT=32, defaults otherwise, randomized runs
//   u_sm  : loopback CUT, N_IN=2, SIG_W=4, MISR_POLY=3, PAT_CNT=4, GOLDEN=3
//   u_l3  : loopback CUT, N_IN=3, LFSR_POLY=3'b011, PAT_CNT=7, LFSR mode
// Honours BIST_PAUSE_EN when defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bist_pattern_ctrl;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bist_pattern_ctrl_if #(.N_IN(5), .N_OUT(2), .SIG_W(16)) c_if ();
    bist_pattern_ctrl_if #(.N_IN(2), .N_OUT(2), .SIG_W(4))  s_if ();
    bist_pattern_ctrl_if #(.N_IN(3), .N_OUT(3), .SIG_W(4))  l_if ();

    bist_pattern_ctrl #(
        .N_IN(5), .N_OUT(2), .SIG_W(16), .PAT_CNT(32),
        .LFSR_POLY(5'b00101), .MISR_POLY(16'h002D), .GOLDEN(16'h0000)
    ) u_c17 (.clk(clk), .rst_n(rst_n), .bus(c_if));

    bist_pattern_ctrl #(
        .N_IN(2), .N_OUT(2), .SIG_W(4), .PAT_CNT(4),
        .LFSR_POLY(2'b11), .MISR_POLY(4'h3), .GOLDEN(4'h3)
    ) u_sm (.clk(clk), .rst_n(rst_n), .bus(s_if));

    bist_pattern_ctrl #(
        .N_IN(3), .N_OUT(3), .SIG_W(4), .PAT_CNT(7),
        .LFSR_POLY(3'b011), .MISR_POLY(4'h3), .GOLDEN(4'h0)
    ) u_l3 (.clk(clk), .rst_n(rst_n), .bus(l_if));

    // c17: inputs N1,N2,N3,N6,N7 = p[0..4]; outputs {N23,N22}.
    function automatic logic [1:0] c17_fn(input logic [4:0] p);
        logic n10, n11, n16, n19, n22, n23;
        n10 = ~(p[0] & p[2]);
        n11 = ~(p[2] & p[3]);
        n16 = ~(p[1] & n11);
        n19 = ~(n11 & p[4]);
        n22 = ~(n10 & n16);
        n23 = ~(n16 & n19);
        return {n23, n22};
    endfunction

    assign c_if.resp_in = c17_fn(c_if.pat_out);
    assign s_if.resp_in = s_if.pat_out;
    assign l_if.resp_in = l_if.pat_out;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model for the c17 instance: pattern list and final signature
    // derived from the sequencing and compaction rules with integer arithmetic.
    int model_pat[32];
    int model_sig;

    task automatic build_model(input bit m);
        int p;
        int s;
        p = m ? 31 : 0;
        for (int i = 0; i < 32; i++) begin
            model_pat[i] = p;
            if (m) p = ((p * 2) % 32) ^ ((p >= 16) ? 5 : 0);
            else   p = (p + 1) % 32;
        end
        s = 0;
        for (int i = 0; i < 32; i++) begin
            s = ((s * 2) % 65536) ^ ((s >= 32768) ? 16'h002D : 0)
              ^ int'(c17_fn(5'(model_pat[i])));
        end
        model_sig = s;
    endtask

    task automatic run_c17(input bit m, input bit extra_starts, output int sig_seen);
        int k;
        int cycles;
        int npause;
        bit p;
        build_model(m);
        @(negedge clk);
        c_if.start = 1'b1;
        c_if.mode  = m;
        @(negedge clk);
        c_if.start = 1'b0;
        c_if.mode  = 1'($urandom);
        k = 0; cycles = 0; npause = 0;
        check_val("c17_start_sig", c_if.signature, 0);
        check_val("c17_start_done", c_if.done, 0);
        check_val("c17_start_pass", c_if.pass, 0);
        while (k < 32 && cycles < 200) begin
            check_val("c17_pat", c_if.pat_out, model_pat[k]);
            check_val("c17_busy", c_if.busy, 1);
            check_val("c17_done_run", c_if.done, 0);
            c_if.start = extra_starts && (cycles == 2 || cycles == 5);
            c_if.mode  = 1'($urandom);
            p = 1'b0;
`ifdef BIST_PAUSE_EN
            p = (cycles > 3) && (npause < 3) && ($urandom_range(0, 3) == 0);
            c_if.pause = p;
`endif
            if (p) npause++;
            else   k++;
            @(negedge clk);
            cycles++;
        end
        c_if.start = 1'b0;
`ifdef BIST_PAUSE_EN
        c_if.pause = 1'b0;
`endif
        check_val("c17_cycles", cycles, 32 + npause);
        check_val("c17_done", c_if.done, 1);
        check_val("c17_busy_end", c_if.busy, 0);
        check_val("c17_sig", c_if.signature, model_sig);
        check_val("c17_pass", c_if.pass, (model_sig == 0) ? 1 : 0);
        check_val("c17_pat_hold", c_if.pat_out, model_pat[31]);
        sig_seen = int'(c_if.signature);
        $display("run c17 mode=%0d extra_starts=%0d pauses=%0d sig=0x%04h model=0x%04h",
                 m, extra_starts, npause, c_if.signature, model_sig[15:0]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_pat"},  c_if.pat_out, 0);
        check_val({tag, "_sig"},  c_if.signature, 0);
        check_val({tag, "_busy"}, c_if.busy, 0);
        check_val({tag, "_done"}, c_if.done, 0);
        check_val({tag, "_pass"}, c_if.pass, 0);
    endtask

    task automatic run_small();
        int sig_tab[4];
        sig_tab = '{0, 1, 0, 3};
        @(negedge clk);
        s_if.start = 1'b1;
        s_if.mode  = 1'b0;
        @(negedge clk);
        s_if.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_val("sm_pat", s_if.pat_out, k);
            check_val("sm_sig", s_if.signature, (k == 0) ? 0 : sig_tab[k-1]);
            check_val("sm_done_run", s_if.done, 0);
            @(negedge clk);
        end
        check_val("sm_sig_final", s_if.signature, 3);
        check_val("sm_done", s_if.done, 1);
        check_val("sm_pass", s_if.pass, 1);
        $display("run small loopback sig=0x%0h pass=%0d", s_if.signature, s_if.pass);
    endtask

    task automatic run_lfsr3();
        int pat_tab[7];
        int nbusy;
        pat_tab = '{7, 5, 1, 2, 4, 3, 6};
        nbusy = 0;
        @(negedge clk);
        l_if.start = 1'b1;
        l_if.mode  = 1'b1;
        @(negedge clk);
        l_if.start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c < 7) check_val("l3_pat", l_if.pat_out, pat_tab[c]);
            if (l_if.busy) nbusy++;
            @(negedge clk);
        end
        check_val("l3_busy_cycles", nbusy, 7);
        check_val("l3_done", l_if.done, 1);
        $display("run lfsr3 busy_cycles=%0d", nbusy);
    endtask

    initial begin
        int sig_a;
        int sig_b;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        c_if.start = 1'b0; c_if.mode = 1'b0;
        s_if.start = 1'b0; s_if.mode = 1'b0;
        l_if.start = 1'b0; l_if.mode = 1'b0;
`ifdef BIST_PAUSE_EN
        c_if.pause = 1'b0; s_if.pause = 1'b0; l_if.pause = 1'b0;
`endif
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        run_small();
        run_lfsr3();

        run_c17(1'b0, 1'b0, sig_a);
        run_c17(1'b1, 1'b0, sig_b);
        run_c17(1'b0, 1'b1, sig_b);
        check_val("c17_extra_start_same", sig_b, sig_a);
        for (int r = 0; r < 4; r++) begin
            run_c17(1'($urandom), 1'($urandom), sig_b);
        end

        // Abort a run near pattern 10 with an asynchronous reset.
        @(negedge clk);
        c_if.start = 1'b1;
        c_if.mode  = 1'b0;
        @(negedge clk);
        c_if.start = 1'b0;
        repeat (10) @(negedge clk);
        check_val("abort_pat_before", c_if.pat_out, 10);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort_idle");
        $display("run abort at pattern 10");
        run_c17(1'b0, 1'b0, sig_b);
        check_val("abort_rerun_same", sig_b, sig_a);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
